pcm_bank_router: RTL and testbench

Parametrised router between a sample-playback chip's linear ROM read port (e.g. YMZ280B, 24-bit byte address) and NB independent SDRAM ROM banks of 2^BW bytes each. It replaces the combinational bank decode in the sound modules with a registered request/acknowledge state machine, held bank addresses and a one-entry last-byte cache. Out-of-range accesses complete with a fill byte. It sits between the sound chip instance and the jtframe ROM slot ports inside each `*_sound` module.

---
 rtl/pcm_bank_router.sv | 145 ++++++++++++++
 tb/tb_pcm_bank_router.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_bank_router.sv
// rtl/pcm_bank_router.sv - linear byte-read router onto NB SDRAM ROM banks with a one-entry cache
// Optional WAIT-cycle timeout enabled by defining PCM_ROUTER_TIMEOUT_EN.
module pcm_bank_router #(
  parameter int          NB      = 3,
  parameter int          AW      = 24,
  parameter int          BW      = 22,
  parameter logic [7:0]  FILL    = 8'h00,
  parameter int          TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_rd_i,
  input  logic [AW-1:0]    req_addr_i,
  output logic [7:0]       req_dout_o,
  output logic             req_valid_o,
  output logic [NB-1:0]    bank_cs_o,
  output logic [NB*BW-1:0] bank_addr_o,
  input  logic [NB*8-1:0]  bank_dout_i,
  input  logic [NB-1:0]    bank_ok_i,
  output logic             timeout_err_o
);

  localparam int IW = AW - BW;
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q;
  logic [7:0]      dout_q;
  logic            valid_q;
  logic [NB-1:0]   bank_cs_q;
  logic [BW-1:0]   addr_q [NB];
  logic [SW-1:0]   sel_q;
  logic [AW-1:0]   lat_addr_q;
  logic            first_q;
  logic            cache_vld_q;
  logic [AW-1:0]   cache_addr_q;
  logic [7:0]      cache_data_q;
`ifdef PCM_ROUTER_TIMEOUT_EN
  logic [10:0]     cnt_q;
  logic            terr_q;
`endif

  logic [IW-1:0]   req_idx_d;
  logic [SW-1:0]   sel_d;
  logic            in_range_d;
  logic            hit_d;
  logic [7:0]      dout_a [NB];

  assign req_idx_d  = req_addr_i[AW-1:BW];
  assign sel_d      = SW'(req_idx_d);
  assign in_range_d = (32'(req_idx_d) < NB);
  assign hit_d      = cache_vld_q && (cache_addr_q == req_addr_i);

  for (genvar g = 0; g < NB; g++) begin : g_bank
    assign dout_a[g]                 = bank_dout_i[g*8 +: 8];
    assign bank_addr_o[g*BW +: BW]   = addr_q[g];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      dout_q       <= 8'h00;
      valid_q      <= 1'b0;
      bank_cs_q    <= '0;
      for (int i = 0; i < NB; i++) addr_q[i] <= '0;
      sel_q        <= '0;
      lat_addr_q   <= '0;
      first_q      <= 1'b0;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= 8'h00;
`ifdef PCM_ROUTER_TIMEOUT_EN
      cnt_q        <= '0;
      terr_q       <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_rd_i) begin
            if (hit_d) begin
              dout_q  <= cache_data_q;
              state_q <= S_DONE;
            end else if (!in_range_d) begin
              dout_q  <= FILL;
              state_q <= S_DONE;
            end else begin
              sel_q         <= sel_d;
              lat_addr_q    <= req_addr_i;
              bank_cs_q     <= NB'(1) << sel_d;
              addr_q[sel_d] <= req_addr_i[BW-1:0];
              first_q       <= 1'b1;
`ifdef PCM_ROUTER_TIMEOUT_EN
              cnt_q         <= '0;
`endif
              state_q       <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          first_q <= 1'b0;
`ifdef PCM_ROUTER_TIMEOUT_EN
          cnt_q   <= cnt_q + 11'd1;
`endif
          // OK in the first WAIT cycle may still belong to the previous address
          if (!first_q && bank_ok_i[sel_q]) begin
            dout_q       <= dout_a[sel_q];
            cache_vld_q  <= 1'b1;
            cache_addr_q <= lat_addr_q;
            cache_data_q <= dout_a[sel_q];
            bank_cs_q    <= '0;
            state_q      <= S_DONE;
          end
`ifdef PCM_ROUTER_TIMEOUT_EN
          else if (cnt_q == 11'(TIMEOUT)) begin
            dout_q    <= FILL;
            bank_cs_q <= '0;
            terr_q    <= 1'b1;
            state_q   <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          valid_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_dout_o  = dout_q;
  assign req_valid_o = valid_q;
  assign bank_cs_o   = bank_cs_q;

`ifdef PCM_ROUTER_TIMEOUT_EN
  assign timeout_err_o = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_bank_router.sv
// tb/tb_pcm_bank_router.sv - scoreboard bench for pcm_bank_router with a cache/bank reference model
module tb_pcm_bank_router;
  localparam int NB = 3;
  localparam int AW = 24;
  localparam int BW = 22;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_rd;
  logic [AW-1:0]     req_addr;
  logic [7:0]        req_dout;
  logic              req_valid;
  logic [NB-1:0]     bank_cs;
  logic [NB*BW-1:0]  bank_addr;
  logic [NB*8-1:0]   bank_dout;
  logic [NB-1:0]     bank_ok;
  logic              terr;

  pcm_bank_router dut (
    .clk_i(clk), .rst_i(rst), .req_rd_i(req_rd), .req_addr_i(req_addr),
    .req_dout_o(req_dout), .req_valid_o(req_valid), .bank_cs_o(bank_cs),
    .bank_addr_o(bank_addr), .bank_dout_i(bank_dout), .bank_ok_i(bank_ok),
    .timeout_err_o(terr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]       data;
    int               lat;
    int               issue;
    logic [NB*BW-1:0] snap;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // reference model: cached (address, byte) pair and last address given to each bank
  bit           m_cvld;
  logic [23:0]  m_caddr;
  logic [7:0]   m_cdata;
  logic [21:0]  m_held [NB];

  // bank model: mode 0 answers after a delay, 1 holds OK high, 2 never answers
  int bank_mode [NB];
  int bank_delay;
  int bcnt [NB];

  function automatic logic [7:0] mem(input int b, input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ (8'h5A + 8'(b));
  endfunction

  function automatic logic [NB*BW-1:0] snap();
    logic [NB*BW-1:0] s;
    for (int i = 0; i < NB; i++) s[i*BW +: BW] = m_held[i];
    return s;
  endfunction

  always_comb begin
    bank_dout = '0;
    bank_ok   = '0;
    for (int i = 0; i < NB; i++) begin
      bank_dout[i*8 +: 8] = mem(i, bank_addr[i*BW +: BW]);
      bank_ok[i] = (bank_mode[i] == 1) ||
                   (bank_mode[i] == 0 && bank_cs[i] && bcnt[i] > bank_delay);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NB; i++) bcnt[i] <= bank_cs[i] ? bcnt[i] + 1 : 0;
  end

  task automatic chk(input string nm, input logic [NB*BW-1:0] act, input logic [NB*BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && req_valid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got dout %0h expected no completion", req_dout);
      end else begin
        mon_e = sbq.pop_front();
        chk("dout", 66'(req_dout), 66'(mon_e.data));
        chk("latency", 66'(cyc - mon_e.issue - 1), 66'(mon_e.lat));
        chk("bank_addr", bank_addr, mon_e.snap);
        chk("cs_at_valid", 66'(bank_cs), 66'(0));
        chk("terr", 66'(terr), 66'(0));
      end
    end
  end

  task automatic model_reset();
    m_cvld = 0;
    for (int i = 0; i < NB; i++) m_held[i] = '0;
    sbq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic issue(input logic [23:0] a, input int d, input bit disturb);
    exp_t e;
    bit   miss;
    bit   seen;
    int   idx;
    idx        = int'(a[23:22]);
    bank_delay = d;
    miss       = 0;
    if (m_cvld && a == m_caddr) begin
      e.data = m_cdata;
      e.lat  = 1;
    end else if (idx >= NB) begin
      e.data = 8'h00;
      e.lat  = 1;
    end else begin
      miss        = 1;
      e.data      = mem(idx, a[21:0]);
      m_held[idx] = a[21:0];
      m_cvld      = 1;
      m_caddr     = a;
      m_cdata     = e.data;
      e.lat       = (bank_mode[idx] == 1) ? 3 : ((d + 2 > 3) ? d + 2 : 3);
    end
    e.snap  = snap();
    e.issue = cyc;
    sbq.push_back(e);
    req_rd   = 1'b1;
    req_addr = a;
    seen     = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (n == 0 && disturb && miss) begin
        req_addr = $urandom;
        if ($urandom_range(1) == 1) req_rd = 1'b0;
      end
      if (req_valid) seen = 1;
    end
    req_rd = 1'b0;
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL completion_timeout: no valid for addr %0h within 60 cycles", a);
      do_reset();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a;
    int r;
    rst        = 1'b1;
    req_rd     = 1'b0;
    req_addr   = '0;
    bank_delay = 0;
    for (int i = 0; i < NB; i++) bank_mode[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cs", 66'(bank_cs), 66'(0));
    chk("rst_valid", 66'(req_valid), 66'(0));
    chk("rst_dout", 66'(req_dout), 66'(0));
    chk("rst_terr", 66'(terr), 66'(0));
    chk("rst_addr", bank_addr, 66'(0));
    rst = 1'b0;
    @(negedge clk);

    issue(24'h000010, 4, 0);
    bank_mode[1] = 1;
    issue(24'h400123, 0, 0);
    bank_mode[1] = 0;
    issue(24'h400123, 0, 0);
    do_reset();
    issue(24'h400123, 0, 0);
    issue(24'hC00000, 0, 0);
    issue(24'hC00000, 0, 0);

    // bank 0 never answers: access must stay pending, then reset kills it asynchronously
    bank_mode[0] = 2;
    req_rd   = 1'b1;
    req_addr = 24'h000040;
    repeat (2000) @(negedge clk);
    chk("stuck_cs", 66'(bank_cs), 66'(3'b001));
    chk("stuck_valid", 66'(req_valid), 66'(0));
    chk("stuck_terr", 66'(terr), 66'(0));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cs", 66'(bank_cs), 66'(0));
    chk("async_rst_valid", 66'(req_valid), 66'(0));
    req_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bank_mode[0] = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_cs", 66'(bank_cs), 66'(0));
    issue(24'h400123, 1, 0);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(9);
      if (r < 3 && m_cvld) a = m_caddr;
      else if (r < 5) a = {2'b11, 22'($urandom)};
      else a = {2'($urandom_range(2)), 22'($urandom_range(63))};
      issue(a, $urandom_range(4), $urandom_range(3) == 0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", 66'(sbq.size()), 66'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
